// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter driving a 2-to-4 decoder with an active-low enable.
// A grant is held while its request stays high; the priority pointer advances past the
// requester just served, and at least one IDLE cycle separates consecutive grants.
// All outputs are registered.
// Optional feature: define RR_PREEMPT_EN to cap a grant at MAX_HOLD cycles whenever another
// requester is waiting. Without it, a grant lasts until its request drops.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    output logic [1:0] sel_out,
    output logic       en_n_out,
    output logic       busy_out
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // Elaboration-time guard on the hold limit.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
    end

    state_e     state_q;
    logic [1:0] sel_q;
    logic [1:0] ptr_q;
    logic       en_n_q;
    logic       busy_q;
    logic [1:0] pick;
    logic       preempt;

`ifdef RR_PREEMPT_EN
    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic       others_req;

    // Preempt when the hold limit is reached and some other requester is waiting.
    always_comb begin
        others_req = |(req_in & ~(4'b0001 << sel_q));
        preempt    = (hold_cnt_q == HoldLimit) && others_req;
    end
`else
    assign preempt = 1'b0;
`endif

    // First set request bit searching upward from the priority pointer, wrapping mod 4.
    // Walk from the farthest offset down so the nearest one wins.
    always_comb begin
        pick = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req_in[ptr_q + 2'(k)]) begin
                pick = ptr_q + 2'(k);
            end
        end
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= 2'b00;
            ptr_q      <= 2'b00;
            en_n_q     <= 1'b1;
            busy_q     <= 1'b0;
`ifdef RR_PREEMPT_EN
            hold_cnt_q <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_in) begin
                        state_q    <= StGrant;
                        sel_q      <= pick;
                        en_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef RR_PREEMPT_EN
                        hold_cnt_q <= 8'd0;
`endif
                    end
                end
                StGrant: begin
`ifdef RR_PREEMPT_EN
                    if (hold_cnt_q != HoldLimit) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
`endif
                    if (!req_in[sel_q] || preempt) begin
                        state_q <= StIdle;
                        ptr_q   <= sel_q + 2'd1;
                        en_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    en_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel_out  = sel_q;
    assign en_n_out = en_n_q;
    assign busy_out = busy_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized request traffic
// checked against a cycle-level behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_rr_arbiter_4;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = 4'b0000;
    logic [1:0] sel_out;
    logic       en_n_out;
    logic       busy_out;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    bit m_grant;
    int m_sel;
    int m_ptr;
    int m_hold;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .sel_out  (sel_out),
        .en_n_out (en_n_out),
        .busy_out (busy_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        m_grant = 1'b0;
        m_sel   = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    // One rising edge of the arbitration rules applied to the sampled request vector.
    task automatic model_step(input logic [3:0] req);
        bit         release_now;
        bit         found;
        logic [3:0] others;
        if (!m_grant) begin
            if (req != 4'b0000) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        m_sel = (m_ptr + k) % 4;
                        found = 1'b1;
                    end
                end
                m_grant = 1'b1;
                m_hold  = 0;
            end
        end else begin
            release_now = (req[m_sel] == 1'b0);
            others      = req & ~(4'b0001 << m_sel);
`ifdef RR_PREEMPT_EN
            if (m_hold == MAX_HOLD - 1 && others != 4'b0000) release_now = 1'b1;
`endif
            if (release_now) begin
                m_grant = 1'b0;
                m_ptr   = (m_sel + 1) % 4;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
    endtask

    // Drive a request vector for one cycle; returns 1 ns after the rising edge.
    task automatic drive_cycle(input logic [3:0] req);
        req_in = req;
        @(posedge clk);
        if (rst_n) model_step(req);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        req_in = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req_in = 4'b1111;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (sel_out !== 2'b00 || en_n_out !== 1'b1 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: sel=%0d en_n=%b busy=%b, required sel=0 en_n=1 busy=0",
                     sel_out, en_n_out, busy_out);
        end
        req_in = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive_cycle(4'b0000);
        n_cmp++;
        if (en_n_out !== 1'b1 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: en_n=%b busy=%b, required en_n=1 busy=0",
                     en_n_out, busy_out);
        end
    endtask

    task automatic test_single_request();
        apply_reset();
        req_in = 4'b0100;
        #1;
        n_cmp++;
        if (en_n_out !== 1'b1 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL no_comb_path: en_n=%b busy=%b, required en_n=1 busy=0 before edge",
                     en_n_out, busy_out);
        end
        drive_cycle(4'b0100);
        n_cmp++;
        if (sel_out !== 2'd2 || en_n_out !== 1'b0 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: sel=%0d en_n=%b busy=%b, required sel=2 en_n=0 busy=1",
                     sel_out, en_n_out, busy_out);
        end
        drive_cycle(4'b0000);
    endtask

    task automatic test_rotation();
        logic [3:0] req;
        int         g;
        int         in_grant;
        int         guard;
        apply_reset();
        req      = 4'b1111;
        g        = 0;
        in_grant = 0;
        guard    = 0;
        while (g < 5 && guard < 100) begin
            drive_cycle(req);
            guard++;
            req = 4'b1111;
            if (m_grant) begin
                if (in_grant == 0) begin
                    n_cmp++;
                    if (sel_out !== 2'(g % 4) || en_n_out !== 1'b0) begin
                        n_err++;
                        $display("FAIL rotation_grant%0d: sel=%0d en_n=%b, required sel=%0d en_n=0",
                                 g, sel_out, en_n_out, g % 4);
                    end
                    g++;
                end
                in_grant++;
                if (in_grant == 3) req = 4'b1111 & ~(4'b0001 << m_sel);
            end else begin
                if (in_grant != 0) begin
                    n_cmp++;
                    if (en_n_out !== 1'b1 || busy_out !== 1'b0) begin
                        n_err++;
                        $display("FAIL rotation_gap: en_n=%b busy=%b, required en_n=1 busy=0",
                                 en_n_out, busy_out);
                    end
                end
                in_grant = 0;
            end
        end
        if (g < 5) begin
            n_cmp++;
            n_err++;
            $display("FAIL rotation_timeout: grants seen=%0d, required 5", g);
        end
        drive_cycle(4'b0000);
    endtask

    task automatic test_ptr_wrap();
        apply_reset();
        drive_cycle(4'b0010);
        drive_cycle(4'b0010);
        drive_cycle(4'b0000);
        drive_cycle(4'b1000);
        n_cmp++;
        if (sel_out !== 2'd3 || en_n_out !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_grant3: sel=%0d en_n=%b, required sel=3 en_n=0",
                     sel_out, en_n_out);
        end
        drive_cycle(4'b1000);
        drive_cycle(4'b0000);
        drive_cycle(4'b0000);
        n_cmp++;
        if (sel_out !== 2'd3 || en_n_out !== 1'b1) begin
            n_err++;
            $display("FAIL idle_sel_hold: sel=%0d en_n=%b, required sel=3 en_n=1",
                     sel_out, en_n_out);
        end
        drive_cycle(4'b1001);
        n_cmp++;
        if (sel_out !== 2'd0 || en_n_out !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_to_0: sel=%0d en_n=%b, required sel=0 en_n=0",
                     sel_out, en_n_out);
        end
        drive_cycle(4'b0000);
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_cycle(4'b0010);
        n_cmp++;
        if (sel_out !== 2'd1 || en_n_out !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_grant: sel=%0d en_n=%b, required sel=1 en_n=0",
                     sel_out, en_n_out);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (en_n_out !== 1'b1 || sel_out !== 2'd0 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_drop: sel=%0d en_n=%b busy=%b, required sel=0 en_n=1 busy=0",
                     sel_out, en_n_out, busy_out);
        end
        #2;
        rst_n = 1'b1;
        drive_cycle(4'b0010);
        n_cmp++;
        if (sel_out !== 2'd1 || en_n_out !== 1'b0 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL regrant_after_reset: sel=%0d en_n=%b busy=%b, required sel=1 en_n=0 busy=1",
                     sel_out, en_n_out, busy_out);
        end
        drive_cycle(4'b0000);
    endtask

    task automatic test_hold_limit();
        int         p;
        logic       exp_en;
        logic [1:0] exp_sel;
        apply_reset();
        for (int c = 1; c <= 30; c++) begin
            drive_cycle(4'b0011);
`ifdef RR_PREEMPT_EN
            p       = (c - 1) % 10;
            exp_en  = (p == 4 || p == 9) ? 1'b1 : 1'b0;
            exp_sel = (p < 5) ? 2'd0 : 2'd1;
`else
            p       = c;
            exp_en  = 1'b0;
            exp_sel = 2'd0;
`endif
            n_cmp++;
            if (sel_out !== exp_sel || en_n_out !== exp_en || busy_out !== ~exp_en) begin
                n_err++;
                $display("FAIL hold_pair_c%0d: sel=%0d en_n=%b busy=%b, required sel=%0d en_n=%b",
                         c, sel_out, en_n_out, busy_out, exp_sel, exp_en);
            end
        end
        apply_reset();
        for (int c = 1; c <= 20; c++) begin
            drive_cycle(4'b0001);
            n_cmp++;
            if (sel_out !== 2'd0 || en_n_out !== 1'b0) begin
                n_err++;
                $display("FAIL hold_alone_c%0d: sel=%0d en_n=%b, required sel=0 en_n=0",
                         c, sel_out, en_n_out);
            end
        end
        drive_cycle(4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic [1:0] exp_sel;
        logic       exp_en;
        apply_reset();
        req = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if (m_grant && $urandom_range(0, 5) == 0) req[m_sel] = 1'b0;
            drive_cycle(req);
            exp_sel = 2'(m_sel);
            exp_en  = m_grant ? 1'b0 : 1'b1;
            n_cmp++;
            if (sel_out !== exp_sel || en_n_out !== exp_en || busy_out !== ~exp_en) begin
                n_err++;
                $display("FAIL random_c%0d: req=%b sel=%0d en_n=%b busy=%b, required sel=%0d en_n=%b",
                         c, req, sel_out, en_n_out, busy_out, exp_sel, exp_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_rotation();
        test_ptr_wrap();
        test_async_reset();
        test_hold_limit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
